// File: rtl/sync_fifo_burst_reader.sv
// sync_fifo_burst_reader
//   Drains a sync_fifo read port as length-controlled bursts. A command
//   carries the burst length (beats minus one). Exactly that many beats are
//   moved from the FIFO to a registered downstream stream, and the final beat
//   is flagged with last_o. The FIFO is never read outside an accepted command.
//
// Ports
//   clock        : rising-edge clock
//   reset        : synchronous, active-low reset
//   cmd_valid_i  : burst command valid
//   cmd_ready_o  : command accepted (high only while idle)
//   cmd_len_i    : burst length minus one
//   valid_i      : FIFO read data valid
//   ready_o      : ready to FIFO read port (combinational)
//   data_i       : FIFO read data
//   valid_o      : downstream valid (registered)
//   ready_i      : downstream ready
//   data_o       : downstream data (registered)
//   last_o       : final beat of the burst, qualified by valid_o
//   busy_o       : burst in progress
module sync_fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LBITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LBITS-1:0] cmd_len_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [LBITS-1:0]   r_remain;
    logic               r_valid;
    logic               r_last;
    logic [WIDTH-1:0]   r_data;

    logic               w_in_acc;
    logic               w_out_acc;
    logic               w_final;

    // FIFO may advance only while transferring and when the output register
    // is empty or is being emptied this cycle.
    assign ready_o     = (r_state == S_XFER) && (!r_valid || ready_i);
    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);

    assign w_in_acc  = valid_i && ready_o;
    assign w_out_acc = r_valid && ready_i;
    assign w_final   = (r_remain == '0);

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_remain <= cmd_len_i;
                        r_state  <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_in_acc) begin
                        // Load wins over a simultaneous output accept, so
                        // valid_o stays high across back-to-back beats.
                        r_data  <= data_i;
                        r_valid <= 1'b1;
                        r_last  <= w_final;
                        // Exit test precedes the decrement, so remain never wraps.
                        if (w_final) r_state  <= S_DRAIN;
                        else         r_remain <= r_remain - 1'b1;
                    end else if (w_out_acc) begin
                        r_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_out_acc) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Directed bench with a FIFO model feeding the reader and a scoreboard of
// expected output beats checked by an independent monitor.
module tb_sync_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LBITS = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [LBITS-1:0] cmd_len_i;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             last_o;
    logic             busy_o;

    sync_fifo_burst_reader #(.WIDTH(WIDTH), .LBITS(LBITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    // FIFO model: fifo_mem[0]=A5, fifo_mem[k]=(k-1)&FF afterwards.
    logic [WIDTH-1:0] fifo_mem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int cyc    = 0;
    logic vld_en  = 1'b1;
    logic starve  = 1'b0;
    logic rdy_base = 1'b1;
    logic tog_en  = 1'b0;
    logic tog_bit = 1'b0;

    assign valid_i = vld_en && (rd_ptr != wr_ptr) && (!starve || (cyc % 3 == 0));
    assign data_i  = fifo_mem[rd_ptr[9:0]];
    assign ready_i = tog_en ? tog_bit : rdy_base;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        tog_bit <= ~tog_bit;
        if (valid_i && ready_o) rd_ptr <= rd_ptr + 1;
    end

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             l;
    } beat_t;
    beat_t exp_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push_range(input int start, input int n, input bit with_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = WIDTH'((start + i) & 8'hFF);
            b.l = with_last && (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: scoreboard compare, stall stability, busy drop after last.
    int   beat_cnt   = 0;
    int   first_edge = 0;
    int   last_edge  = 0;
    int   cmd_edge   = 0;
    bit   prev_stall = 0;
    bit   after_last = 0;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;

    always @(negedge clock) begin
        beat_t b;
        if (!reset) begin
            prev_stall = 0;
            after_last = 0;
            beat_cnt   = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, valid_o}, 32'd1);
                check("stall_data", {24'd0, data_o}, {24'd0, prev_data});
                check("stall_last", {31'd0, last_o}, {31'd0, prev_last});
            end
            if (after_last) begin
                check("busy_after_last", {31'd0, busy_o}, 32'd0);
                after_last = 0;
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("stray_beat", {24'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", {24'd0, data_o}, {24'd0, b.d});
                    check("beat_last", {31'd0, last_o}, {31'd0, b.l});
                end
                if (beat_cnt == 0) first_edge = cyc + 1;
                beat_cnt++;
                if (last_o) begin
                    last_edge  = cyc + 1;
                    beat_cnt   = 0;
                    after_last = 1;
                end
            end
            if (cmd_valid_i && cmd_ready_o) cmd_edge = cyc + 1;
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
        end
    end

    task automatic send_cmd(input int len);
        int n;
        n = 0;
        cmd_len_i   = LBITS'(len);
        cmd_valid_i = 1'b1;
        forever begin
            @(negedge clock);
            if (cmd_ready_o) break;
            n++;
            if (n > 1000) begin
                check("cmd_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clock); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock); #1;
            if (exp_q.size() == 0 && !busy_o) begin
                done = 1;
                break;
            end
        end
        check("burst_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_mem[0] = 8'hA5;
        for (int k = 1; k < 1024; k++) fifo_mem[k] = WIDTH'((k - 1) & 8'hFF);
        wr_ptr      = 700;
        reset       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;

        // Reset held two cycles with FIFO data offered.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_last_o", {31'd0, last_o}, 32'd0);
        check("rst_ready_o", {31'd0, ready_o}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_no_pop", rd_ptr, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock); #1;
        check("idle_no_pop", rd_ptr, 32'd0);

        // Single beat A5.
        push_range(8'hA5, 1, 1);
        send_cmd(0);
        wait_idle(50);
        check("single_rd_ptr", rd_ptr, 32'd1);

        // Streaming burst 0..9 on consecutive cycles, then 10 next.
        push_range(0, 10, 1);
        send_cmd(9);
        wait_idle(100);
        check("stream_span", last_edge - first_edge, 32'd9);
        check("stream_rd_ptr", rd_ptr, 32'd11);
        push_range(10, 1, 1);
        send_cmd(0);
        wait_idle(50);

        // Backpressure: ready_i toggling.
        tog_en = 1'b1;
        push_range(11, 8, 1);
        send_cmd(7);
        wait_idle(200);
        tog_en = 1'b0;
        check("bp_rd_ptr", rd_ptr, 32'd20);

        // Starved input plus a queued second command.
        starve = 1'b1;
        push_range(19, 4, 1);
        push_range(23, 1, 1);
        send_cmd(3);
        send_cmd(0);
        check("queued_cmd_gap", cmd_edge - last_edge, 32'd1);
        wait_idle(200);
        starve = 1'b0;
        check("starve_rd_ptr", rd_ptr, 32'd25);

        // Maximum length: 256 beats.
        push_range(24, 256, 1);
        send_cmd(255);
        wait_idle(1000);
        check("max_rd_ptr", rd_ptr, 32'd281);

        // Abort after five beats of a 16-beat burst.
        push_range(24, 5, 0);
        send_cmd(15);
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (beat_cnt == 5) break;
        end
        check("abort_beats", beat_cnt, 32'd5);
        reset    = 1'b0;
        rdy_base = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort_valid_o", {31'd0, valid_o}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_rd_ptr", rd_ptr, 32'd287);
        @(posedge clock); #1;
        reset    = 1'b1;
        rdy_base = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("abort_no_pop", rd_ptr, 32'd287);
        check("abort_queue", exp_q.size(), 32'd0);
        check("abort_idle_valid", {31'd0, valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
